// File: rtl/police_dispatch_ctrl.sv
// Police response sequencer: alert delay, car drive-in, officer walk to the corpse and back,
// car drive-out, plus the player-catch detector with a sticky game_over.
module police_dispatch_ctrl #(
  parameter logic [9:0]  CAR_START_X    = 10'd700,
  parameter logic [9:0]  CAR_STOP_X     = 10'd100,
  parameter logic [9:0]  CAR_Y          = 10'd40,
  parameter int unsigned CAR_SPEED      = 4,
  parameter int unsigned WALK_SPEED     = 2,
  parameter int unsigned ALERT_FRAMES   = 60,
  parameter int unsigned COLLECT_FRAMES = 90,
  parameter logic [9:0]  CATCH_RADIUS   = 10'd16
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_start,
  input  logic       restart,
  input  logic       corpse_discovered,
  input  logic [9:0] death_X,
  input  logic [9:0] death_Y,
  input  logic [9:0] player_X,
  input  logic [9:0] player_Y,
  output logic [9:0] police_car_X,
  output logic [9:0] police_car_Y,
  output logic [9:0] police_X,
  output logic [9:0] police_Y,
  output logic       police_out,
  output logic       reached,
  output logic       collected,
  output logic       game_over,
  output logic       busy
);

  localparam int unsigned POS_W   = 10;
  localparam int unsigned DIFF_W  = 11;
  localparam int unsigned CNT_MAX = (ALERT_FRAMES > COLLECT_FRAMES) ? ALERT_FRAMES : COLLECT_FRAMES;
  localparam int unsigned CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [DIFF_W-1:0] CAR_STEP  = DIFF_W'(CAR_SPEED);
  localparam logic [DIFF_W-1:0] WALK_STEP = DIFF_W'(WALK_SPEED);
  localparam logic [DIFF_W-1:0] RADIUS    = DIFF_W'(CATCH_RADIUS);

  typedef enum logic [3:0] {
    S_IDLE, S_ALERT, S_DRIVE_IN, S_DEPLOY, S_COLLECT,
    S_RETURN, S_DRIVE_OUT, S_DONE, S_CAUGHT
  } state_e;

  state_e           state_q, state_d;
  logic [POS_W-1:0] car_x_q, car_x_d;
  logic [POS_W-1:0] pol_x_q, pol_x_d;
  logic [POS_W-1:0] pol_y_q, pol_y_d;
  logic [POS_W-1:0] tgt_x_q, tgt_x_d;
  logic [POS_W-1:0] tgt_y_q, tgt_y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             reached_q, reached_d;
  logic             collected_q, collected_d;
  logic             over_q, over_d;
  logic             busy_q, busy_d;
  logic             catch_c;

  function automatic logic [DIFF_W-1:0] abs_diff(input logic [POS_W-1:0] a,
                                                 input logic [POS_W-1:0] b);
    logic signed [DIFF_W-1:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return d[DIFF_W-1] ? DIFF_W'(-d) : DIFF_W'(d);
  endfunction

  // Move one step toward tgt, clamped so the target is never overshot.
  function automatic logic [POS_W-1:0] step_to(input logic [POS_W-1:0] cur,
                                               input logic [POS_W-1:0] tgt,
                                               input logic [DIFF_W-1:0] spd);
    if (abs_diff(tgt, cur) <= spd) return tgt;
    else if (tgt > cur)            return cur + POS_W'(spd);
    else                           return cur - POS_W'(spd);
  endfunction

  assign catch_c = out_q && !reached_q &&
                   (abs_diff(player_X, pol_x_q) <= RADIUS) &&
                   (abs_diff(player_Y, pol_y_q) <= RADIUS);

  always_comb begin
    state_d     = state_q;
    car_x_d     = car_x_q;
    pol_x_d     = pol_x_q;
    pol_y_d     = pol_y_q;
    tgt_x_d     = tgt_x_q;
    tgt_y_d     = tgt_y_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    reached_d   = reached_q;
    collected_d = collected_q;
    over_d      = over_q;
    if (restart) begin
      state_d     = S_IDLE;
      car_x_d     = CAR_START_X;
      pol_x_d     = CAR_STOP_X;
      pol_y_d     = CAR_Y;
      tgt_x_d     = '0;
      tgt_y_d     = '0;
      cnt_d       = '0;
      out_d       = 1'b0;
      reached_d   = 1'b0;
      collected_d = 1'b0;
      over_d      = 1'b0;
    end else if (catch_c) begin
      state_d = S_CAUGHT;
      over_d  = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: if (corpse_discovered) begin
          tgt_x_d = death_X;
          tgt_y_d = death_Y;
          cnt_d   = CNT_W'(ALERT_FRAMES);
          state_d = S_ALERT;
        end
        S_ALERT: if (frame_start) begin
          if (cnt_q == '0) state_d = S_DRIVE_IN;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        S_DRIVE_IN: if (frame_start) begin
          car_x_d = step_to(car_x_q, CAR_STOP_X, CAR_STEP);
          if (car_x_d == CAR_STOP_X) begin
            state_d = S_DEPLOY;
            out_d   = 1'b1;
          end
        end
        S_DEPLOY: if (frame_start) begin
          if (pol_x_q != tgt_x_q) pol_x_d = step_to(pol_x_q, tgt_x_q, WALK_STEP);
          else                    pol_y_d = step_to(pol_y_q, tgt_y_q, WALK_STEP);
          if (pol_x_d == tgt_x_q && pol_y_d == tgt_y_q) begin
            cnt_d   = CNT_W'(COLLECT_FRAMES);
            state_d = S_COLLECT;
          end
        end
        S_COLLECT: if (frame_start) begin
          if (cnt_q == '0) begin
            collected_d = 1'b1;
            state_d     = S_RETURN;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        // Walk back vertically first, then horizontally, to the car door.
        S_RETURN: if (frame_start) begin
          if (pol_y_q != CAR_Y) pol_y_d = step_to(pol_y_q, CAR_Y, WALK_STEP);
          else                  pol_x_d = step_to(pol_x_q, CAR_STOP_X, WALK_STEP);
          if (pol_x_d == CAR_STOP_X && pol_y_d == CAR_Y) begin
            reached_d = 1'b1;
            state_d   = S_DRIVE_OUT;
          end
        end
        S_DRIVE_OUT: if (frame_start) begin
          car_x_d = step_to(car_x_q, CAR_START_X, CAR_STEP);
          pol_x_d = car_x_d;
          if (car_x_d == CAR_START_X) state_d = S_DONE;
        end
        default: ;
      endcase
    end
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= S_IDLE;
      car_x_q     <= CAR_START_X;
      pol_x_q     <= CAR_STOP_X;
      pol_y_q     <= CAR_Y;
      tgt_x_q     <= '0;
      tgt_y_q     <= '0;
      cnt_q       <= '0;
      out_q       <= 1'b0;
      reached_q   <= 1'b0;
      collected_q <= 1'b0;
      over_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      car_x_q     <= car_x_d;
      pol_x_q     <= pol_x_d;
      pol_y_q     <= pol_y_d;
      tgt_x_q     <= tgt_x_d;
      tgt_y_q     <= tgt_y_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      reached_q   <= reached_d;
      collected_q <= collected_d;
      over_q      <= over_d;
      busy_q      <= busy_d;
    end
  end

  assign police_car_X = car_x_q;
  assign police_car_Y = CAR_Y;
  assign police_X     = pol_x_q;
  assign police_Y     = pol_y_q;
  assign police_out   = out_q;
  assign reached      = reached_q;
  assign collected    = collected_q;
  assign game_over    = over_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_police_dispatch_ctrl.sv
// Directed bench for police_dispatch_ctrl: a per-cycle vector table for the start-up
// sequence, then hand-written runs through drive-in, walk, collect, return, drive-out and catch.
module tb_police_dispatch_ctrl;

  localparam logic [9:0] START_X = 10'd250;
  localparam logic [9:0] STOP_X  = 10'd100;
  localparam logic [9:0] ROW_Y   = 10'd40;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       frame_start, restart, corpse_discovered;
  logic [9:0] death_X, death_Y, player_X, player_Y;
  logic [9:0] police_car_X, police_car_Y, police_X, police_Y;
  logic       police_out, reached, collected, game_over, busy;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  police_dispatch_ctrl #(
    .CAR_START_X   (START_X),
    .CAR_STOP_X    (STOP_X),
    .CAR_Y         (ROW_Y),
    .CAR_SPEED     (4),
    .WALK_SPEED    (2),
    .ALERT_FRAMES  (2),
    .COLLECT_FRAMES(3),
    .CATCH_RADIUS  (10'd16)
  ) u_dut (
    .Clk              (Clk),
    .Reset_n          (Reset_n),
    .frame_start      (frame_start),
    .restart          (restart),
    .corpse_discovered(corpse_discovered),
    .death_X          (death_X),
    .death_Y          (death_Y),
    .player_X         (player_X),
    .player_Y         (player_Y),
    .police_car_X     (police_car_X),
    .police_car_Y     (police_car_Y),
    .police_X         (police_X),
    .police_Y         (police_Y),
    .police_out       (police_out),
    .reached          (reached),
    .collected        (collected),
    .game_over        (game_over),
    .busy             (busy)
  );

  typedef struct {
    logic       rst;
    logic       cd;
    logic       fs;
    logic [9:0] dx;
    logic [9:0] dy;
    logic       exp_busy;
    logic [9:0] exp_car;
    logic       exp_out;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    cyc();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_car_x"}, int'(police_car_X), int'(START_X));
    chk({tag, "_car_y"}, int'(police_car_Y), int'(ROW_Y));
    chk({tag, "_pol_x"}, int'(police_X), int'(STOP_X));
    chk({tag, "_pol_y"}, int'(police_Y), int'(ROW_Y));
    chk({tag, "_flags"}, int'({police_out, reached, collected, game_over, busy}), 0);
  endtask

  // Discovery at (300,250), 3 alert frames and 38 drive-in frames reach DEPLOY.
  task automatic go_deploy();
    death_X = 10'd300;
    death_Y = 10'd250;
    corpse_discovered = 1'b1;
    cyc();
    corpse_discovered = 1'b0;
    repeat (41) frame();
    chk("deploy_entry_out", int'(police_out), 1);
    chk("deploy_entry_car", int'(police_car_X), int'(STOP_X));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int car_m, last, px, py, n;
    //           rst   cd    fs    dx       dy       busy  car      out
    tbl[0] = '{1'b1, 1'b1, 1'b0, 10'd300, 10'd250, 1'b0, 10'd250, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 10'd300, 10'd250, 1'b1, 10'd250, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 10'd50,  10'd50,  1'b1, 10'd250, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 10'd0,   10'd0,   1'b1, 10'd250, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 10'd0,   10'd0,   1'b1, 10'd250, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 10'd0,   10'd0,   1'b1, 10'd250, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 10'd0,   10'd0,   1'b1, 10'd246, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 10'd0,   10'd0,   1'b1, 10'd246, 1'b0};
    tbl[8] = '{1'b0, 1'b1, 1'b1, 10'd50,  10'd50,  1'b1, 10'd242, 1'b0};
    tbl[9] = '{1'b0, 1'b0, 1'b1, 10'd0,   10'd0,   1'b1, 10'd238, 1'b0};

    Reset_n = 1'b0;
    frame_start = 1'b0;
    restart = 1'b0;
    corpse_discovered = 1'b0;
    death_X = '0;
    death_Y = '0;
    player_X = 10'd1000;
    player_Y = 10'd1000;
    repeat (2) cyc();
    chk_reset("por");
    Reset_n = 1'b1;
    cyc();
    chk_reset("idle");

    for (int i = 0; i < 10; i++) begin
      restart = tbl[i].rst;
      corpse_discovered = tbl[i].cd;
      frame_start = tbl[i].fs;
      death_X = tbl[i].dx;
      death_Y = tbl[i].dy;
      cyc();
      restart = 1'b0;
      corpse_discovered = 1'b0;
      frame_start = 1'b0;
      chk($sformatf("vec%0d_busy", i), int'(busy), int'(tbl[i].exp_busy));
      chk($sformatf("vec%0d_car", i), int'(police_car_X), int'(tbl[i].exp_car));
      chk($sformatf("vec%0d_out", i), int'(police_out), int'(tbl[i].exp_out));
      chk($sformatf("vec%0d_over", i), int'(game_over), 0);
    end

    // Drive-in: 138 px left, 34 steps of 4 then a clamped step of 2.
    car_m = 238;
    n = 0;
    for (int k = 0; k < 60 && police_out !== 1'b1; k++) begin
      frame();
      car_m = (car_m - 100 > 4) ? car_m - 4 : 100;
      n++;
      chk("drive_in_x", int'(police_car_X), car_m);
      chk("drive_in_out", int'(police_out), int'(car_m == 100));
    end
    chk("drive_in_frames", n, 35);
    chk("deploy_pol_x", int'(police_X), 100);
    chk("deploy_pol_y", int'(police_Y), 40);

    // Walk to (300,250), X first; the (50,50) discoveries must have been ignored.
    px = 100;
    py = 40;
    n = 0;
    for (int k = 0; k < 400 && !(px == 300 && py == 250); k++) begin
      frame();
      if (px != 300) px = (300 - px > 2) ? px + 2 : 300;
      else           py = (250 - py > 2) ? py + 2 : 250;
      n++;
      chk("walk_x", int'(police_X), px);
      chk("walk_y", int'(police_Y), py);
    end
    chk("walk_frames", n, 205);

    for (int k = 1; k <= 4; k++) begin
      frame();
      chk($sformatf("collect_f%0d", k), int'(collected), int'(k == 4));
      chk($sformatf("collect_pos%0d", k), int'(police_Y), 250);
    end

    // Return: Y down to 40 first, then X back to 100.
    n = 0;
    for (int k = 0; k < 400 && !(px == 100 && py == 40); k++) begin
      frame();
      if (py != 40) py = (py - 40 > 2) ? py - 2 : 40;
      else          px = (px - 100 > 2) ? px - 2 : 100;
      n++;
      chk("ret_x", int'(police_X), px);
      chk("ret_y", int'(police_Y), py);
      chk("ret_reached", int'(reached), int'(px == 100 && py == 40));
    end
    chk("ret_frames", n, 205);

    // Drive-out: 150 px, 37 steps of 4 then a final step of 2.
    car_m = 100;
    last = 100;
    n = 0;
    for (int k = 0; k < 60 && busy === 1'b1; k++) begin
      frame();
      last = car_m;
      car_m = (250 - car_m > 4) ? car_m + 4 : 250;
      n++;
      chk("drive_out_x", int'(police_car_X), car_m);
      chk("drive_out_pol_x", int'(police_X), car_m);
      chk("drive_out_out", int'(police_out), 1);
    end
    chk("drive_out_frames", n, 38);
    chk("drive_out_last_step", car_m - last, 2);
    chk("done_busy", int'(busy), 0);

    repeat (2) frame();
    chk("done_car", int'(police_car_X), 250);
    chk("done_pol_x", int'(police_X), 250);
    chk("done_sticky", int'({collected, reached, game_over}), 6);

    restart = 1'b1;
    cyc();
    restart = 1'b0;
    chk_reset("restart");

    // Catch boundary: 17 px away on one axis misses, 16 px on both axes catches.
    go_deploy();
    repeat (5) frame();
    chk("pre_catch_x", int'(police_X), 110);
    player_X = 10'd127;
    player_Y = 10'd24;
    repeat (2) cyc();
    chk("no_catch_x17", int'(game_over), 0);
    player_X = 10'd126;
    player_Y = 10'd23;
    repeat (2) cyc();
    chk("no_catch_y17", int'(game_over), 0);
    player_Y = 10'd24;
    chk("catch_pre_edge", int'(game_over), 0);
    cyc();
    chk("catch_over", int'(game_over), 1);
    chk("catch_busy", int'(busy), 1);
    player_X = 10'd1000;
    player_Y = 10'd1000;
    repeat (3) frame();
    chk("frozen_x", int'(police_X), 110);
    chk("frozen_y", int'(police_Y), 40);
    chk("frozen_car", int'(police_car_X), 100);
    chk("frozen_over", int'(game_over), 1);

    restart = 1'b1;
    cyc();
    restart = 1'b0;
    chk_reset("restart2");

    // Asynchronous reset mid-walk, observed before the next clock edge.
    go_deploy();
    repeat (25) frame();
    chk("pre_async_x", int'(police_X), 150);
    #1;
    Reset_n = 1'b0;
    #1;
    chk_reset("async");
    cyc();
    Reset_n = 1'b1;
    cyc();
    chk_reset("post_async");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
